// File: rtl/bcp_impl_queue.sv
// Implication queue for the BCP traversal engine: dedups implications by variable,
// flags contradictory polarities as a conflict, and issues entries one at a time.
module bcp_impl_queue #(
    parameter int unsigned VAR_W     = 11,
    parameter int unsigned ADDR_SIZE = 12,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLEAR,
    input  logic                       IMPL_VALID,
    input  logic [VAR_W-1:0]           IMPL_VAR,
    input  logic                       IMPL_VALUE,
    input  logic                       IMPL_THREAD,
    output logic                       IMPL_READY,
    output logic                       EN,
    output logic [ADDR_SIZE-1:0]       BASE,
    output logic                       VALUE,
    output logic                       THREAD,
    input  logic                       TE_DONE,
    output logic                       CONFLICT,
    output logic [VAR_W-1:0]           CONFLICT_VAR,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       EMPTY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StHalt} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [VAR_W-1:0]   var_mem [DEPTH];
    logic [DEPTH-1:0]   val_mem;
    logic [DEPTH-1:0]   thr_mem;

    logic               push;
    logic               hit;
    logic               hit_val;
    logic               conflict_det;
    logic               do_push;
    logic               pop;
    logic [PTR_W-1:0]   off;

    assign IMPL_READY   = (COUNT < CNT_W'(DEPTH)) && (state_q != StHalt) && !CLEAR && !RST;
    assign EMPTY        = (COUNT == '0);
    assign push         = IMPL_VALID && IMPL_READY;
    assign conflict_det = push && hit && (hit_val != IMPL_VALUE);
    assign do_push      = push && !hit;
    assign pop          = (state_q == StBusy) && TE_DONE;

    // An entry is occupied when its distance from head (mod DEPTH) is below COUNT;
    // this includes the in-flight head entry.
    always_comb begin
        hit     = 1'b0;
        hit_val = 1'b0;
        off     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off = PTR_W'(i) - head_q;
            if (({1'b0, off} < COUNT) && (var_mem[i] == IMPL_VAR)) begin
                hit     = 1'b1;
                hit_val = val_mem[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            var_mem[tail_q] <= IMPL_VAR;
            val_mem[tail_q] <= IMPL_VALUE;
            thr_mem[tail_q] <= IMPL_THREAD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            head_q       <= '0;
            tail_q       <= '0;
            COUNT        <= '0;
            EN           <= 1'b0;
            BASE         <= '0;
            VALUE        <= 1'b0;
            THREAD       <= 1'b0;
            CONFLICT     <= 1'b0;
            CONFLICT_VAR <= '0;
        end else if (CLEAR) begin
            state_q      <= StIdle;
            head_q       <= '0;
            tail_q       <= '0;
            COUNT        <= '0;
            EN           <= 1'b0;
            CONFLICT     <= 1'b0;
            CONFLICT_VAR <= '0;
        end else if (conflict_det) begin
            state_q      <= StHalt;
            head_q       <= '0;
            tail_q       <= '0;
            COUNT        <= '0;
            EN           <= 1'b0;
            CONFLICT     <= 1'b1;
            CONFLICT_VAR <= IMPL_VAR;
        end else begin
            CONFLICT <= 1'b0;
            if (do_push) tail_q <= tail_q + 1'b1;
            if (pop)     head_q <= head_q + 1'b1;
            COUNT <= COUNT + CNT_W'(do_push) - CNT_W'(pop);
            unique case (state_q)
                StIdle: begin
                    if (COUNT != '0) begin
                        BASE    <= ADDR_SIZE'({var_mem[head_q], val_mem[head_q]});
                        VALUE   <= val_mem[head_q];
                        THREAD  <= thr_mem[head_q];
                        EN      <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (TE_DONE) begin
                        EN      <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StHalt: ;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_impl_queue.sv
// Directed bench for bcp_impl_queue: issue latency, dedup, conflict/HALT, full queue,
// pointer wrap under paired push/pop, and asynchronous reset.
module tb_bcp_impl_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLEAR = 1'b0;
    logic        IMPL_VALID = 1'b0;
    logic [10:0] IMPL_VAR = '0;
    logic        IMPL_VALUE = 1'b0;
    logic        IMPL_THREAD = 1'b0;
    logic        IMPL_READY;
    logic        EN;
    logic [11:0] BASE;
    logic        VALUE;
    logic        THREAD;
    logic        TE_DONE = 1'b0;
    logic        CONFLICT;
    logic [10:0] CONFLICT_VAR;
    logic [3:0]  COUNT;
    logic        EMPTY;

    int errors = 0;
    int checks = 0;

    bcp_impl_queue #(.VAR_W(11), .ADDR_SIZE(12), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .CLEAR(CLEAR),
        .IMPL_VALID(IMPL_VALID), .IMPL_VAR(IMPL_VAR), .IMPL_VALUE(IMPL_VALUE),
        .IMPL_THREAD(IMPL_THREAD), .IMPL_READY(IMPL_READY),
        .EN(EN), .BASE(BASE), .VALUE(VALUE), .THREAD(THREAD), .TE_DONE(TE_DONE),
        .CONFLICT(CONFLICT), .CONFLICT_VAR(CONFLICT_VAR), .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [10:0] v, input logic val, input logic thr);
        IMPL_VALID  = 1'b1;
        IMPL_VAR    = v;
        IMPL_VALUE  = val;
        IMPL_THREAD = thr;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", EN); end
        checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", EMPTY); end
        checks++; if (CONFLICT !== 1'b0 || CONFLICT_VAR !== 11'd0 || BASE !== 12'd0)
            begin errors++; $display("FAIL reset_outs: got conf=%0b cvar=%0h base=%0h want 0/0/0", CONFLICT, CONFLICT_VAR, BASE); end
        RST = 1'b0;
        #1;
        checks++; if (IMPL_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", IMPL_READY); end
    endtask

    task automatic test_single_issue;
        offer(11'd5, 1'b1, 1'b0);
        tick;
        IMPL_VALID = 1'b0;
        checks++; if (COUNT !== 4'd1 || EN !== 1'b0)
            begin errors++; $display("FAIL single_edge1: got count=%0d en=%0b want 1/0", COUNT, EN); end
        tick;
        checks++; if (EN !== 1'b1 || BASE !== 12'h00B || VALUE !== 1'b1 || THREAD !== 1'b0)
            begin errors++; $display("FAIL single_issue: got en=%0b base=%0h val=%0b thr=%0b want 1/00b/1/0", EN, BASE, VALUE, THREAD); end
        tick;
        tick;
        TE_DONE = 1'b1;
        tick;
        TE_DONE = 1'b0;
        checks++; if (EN !== 1'b0 || COUNT !== 4'd0 || EMPTY !== 1'b1)
            begin errors++; $display("FAIL single_done: got en=%0b count=%0d empty=%0b want 0/0/1", EN, COUNT, EMPTY); end
    endtask

    task automatic test_duplicate;
        offer(11'd3, 1'b0, 1'b0);
        tick;
        tick;
        IMPL_VALID = 1'b0;
        checks++; if (COUNT !== 4'd1 || EN !== 1'b1 || BASE !== 12'h006)
            begin errors++; $display("FAIL dup_issue: got count=%0d en=%0b base=%0h want 1/1/006", COUNT, EN, BASE); end
        TE_DONE = 1'b1;
        tick;
        TE_DONE = 1'b0;
        checks++; if (COUNT !== 4'd0 || EN !== 1'b0)
            begin errors++; $display("FAIL dup_pop: got count=%0d en=%0b want 0/0", COUNT, EN); end
        tick;
        tick;
        tick;
        checks++; if (EN !== 1'b0) begin errors++; $display("FAIL dup_single_issue: got en=%0b want 0", EN); end
    endtask

    task automatic test_conflict;
        offer(11'd7, 1'b1, 1'b0);
        tick;
        IMPL_VALID = 1'b0;
        tick;
        checks++; if (EN !== 1'b1 || BASE !== 12'h00F)
            begin errors++; $display("FAIL conf_inflight: got en=%0b base=%0h want 1/00f", EN, BASE); end
        offer(11'd7, 1'b0, 1'b1);
        tick;
        IMPL_VALID = 1'b0;
        checks++; if (CONFLICT !== 1'b1 || CONFLICT_VAR !== 11'd7)
            begin errors++; $display("FAIL conf_pulse: got conf=%0b cvar=%0d want 1/7", CONFLICT, CONFLICT_VAR); end
        checks++; if (EN !== 1'b0 || COUNT !== 4'd0 || IMPL_READY !== 1'b0)
            begin errors++; $display("FAIL conf_flush: got en=%0b count=%0d ready=%0b want 0/0/0", EN, COUNT, IMPL_READY); end
        TE_DONE = 1'b1;
        tick;
        TE_DONE = 1'b0;
        checks++; if (CONFLICT !== 1'b0 || CONFLICT_VAR !== 11'd7 || IMPL_READY !== 1'b0 || EN !== 1'b0)
            begin errors++; $display("FAIL conf_halt: got conf=%0b cvar=%0d ready=%0b en=%0b want 0/7/0/0", CONFLICT, CONFLICT_VAR, IMPL_READY, EN); end
        CLEAR = 1'b1;
        #1;
        checks++; if (IMPL_READY !== 1'b0) begin errors++; $display("FAIL clear_ready_low: got %0b want 0", IMPL_READY); end
        tick;
        CLEAR = 1'b0;
        #1;
        checks++; if (IMPL_READY !== 1'b1 || CONFLICT_VAR !== 11'd0)
            begin errors++; $display("FAIL clear_exit: got ready=%0b cvar=%0d want 1/0", IMPL_READY, CONFLICT_VAR); end
        offer(11'd9, 1'b0, 1'b0);
        tick;
        IMPL_VALID = 1'b0;
        tick;
        checks++; if (EN !== 1'b1 || BASE !== 12'h012)
            begin errors++; $display("FAIL clear_idle_issue: got en=%0b base=%0h want 1/012", EN, BASE); end
        TE_DONE = 1'b1;
        tick;
        TE_DONE = 1'b0;
    endtask

    task automatic test_full;
        logic [10:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 11'(10 + k);
            offer(v, 1'b0, 1'b0);
            tick;
        end
        offer(11'd30, 1'b1, 1'b0);
        TE_DONE = 1'b1;
        #1;
        checks++; if (IMPL_READY !== 1'b0 || COUNT !== 4'd8)
            begin errors++; $display("FAIL full_ready: got ready=%0b count=%0d want 0/8", IMPL_READY, COUNT); end
        checks++; if (EN !== 1'b1 || BASE !== 12'h014)
            begin errors++; $display("FAIL full_head: got en=%0b base=%0h want 1/014", EN, BASE); end
        tick;
        IMPL_VALID = 1'b0;
        TE_DONE = 1'b0;
        checks++; if (COUNT !== 4'd7 || EN !== 1'b0)
            begin errors++; $display("FAIL full_refuse: got count=%0d en=%0b want 7/0", COUNT, EN); end
        tick;
        checks++; if (EN !== 1'b1 || BASE !== 12'h016)
            begin errors++; $display("FAIL full_next: got en=%0b base=%0h want 1/016", EN, BASE); end
        CLEAR = 1'b1;
        tick;
        CLEAR = 1'b0;
        checks++; if (COUNT !== 4'd0 || EN !== 1'b0)
            begin errors++; $display("FAIL full_clear: got count=%0d en=%0b want 0/0", COUNT, EN); end
    endtask

    task automatic test_back_to_back;
        int          pushed = 0;
        int          issued = 0;
        int          cycles = 0;
        int          max_cnt = 0;
        logic        prev_en = 1'b0;
        logic        accepted;
        logic [10:0] v;
        logic [11:0] exp_base;
        logic        exp_val;
        logic        exp_thr;
        while (issued < 20 && cycles < 400) begin
            v           = 11'(100 + pushed);
            IMPL_VALID  = (pushed < 20);
            IMPL_VAR    = v;
            IMPL_VALUE  = pushed[0];
            IMPL_THREAD = pushed[1];
            TE_DONE     = EN;
            #1;
            accepted = IMPL_VALID && IMPL_READY;
            tick;
            if (accepted) pushed++;
            if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
            if (EN && !prev_en) begin
                v        = 11'(100 + issued);
                exp_val  = issued[0];
                exp_thr  = issued[1];
                exp_base = {v, exp_val};
                checks++;
                if (BASE !== exp_base || VALUE !== exp_val || THREAD !== exp_thr) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got base=%0h val=%0b thr=%0b want %0h/%0b/%0b",
                             issued, BASE, VALUE, THREAD, exp_base, exp_val, exp_thr);
                end
                issued++;
            end
            prev_en = EN;
            cycles++;
        end
        IMPL_VALID = 1'b0;
        TE_DONE = 1'b0;
        checks++; if (issued != 20) begin errors++; $display("FAIL b2b_timeout: got %0d issues want 20", issued); end
        checks++; if (max_cnt > 8) begin errors++; $display("FAIL b2b_maxcount: got %0d want <=8", max_cnt); end
        CLEAR = 1'b1;
        tick;
        CLEAR = 1'b0;
    endtask

    task automatic test_async_reset;
        offer(11'd40, 1'b1, 1'b0);
        tick;
        IMPL_VALID = 1'b0;
        tick;
        checks++; if (EN !== 1'b1) begin errors++; $display("FAIL arst_busy: got en=%0b want 1", EN); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (EN !== 1'b0 || COUNT !== 4'd0 || CONFLICT !== 1'b0 || EMPTY !== 1'b1)
            begin errors++; $display("FAIL arst_async: got en=%0b count=%0d conf=%0b empty=%0b want 0/0/0/1", EN, COUNT, CONFLICT, EMPTY); end
        tick;
        RST = 1'b0;
        #1;
        checks++; if (IMPL_READY !== 1'b1) begin errors++; $display("FAIL arst_ready: got %0b want 1", IMPL_READY); end
    endtask

    initial begin
        test_reset;
        test_single_issue;
        test_duplicate;
        test_conflict;
        test_full;
        test_back_to_back;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
